// File: rtl/regfile_pkg.sv
// ============================================================================
// Module  : regfile_pkg
// Brief   : Shared sizes, requester ids and constants for the write-back path.
// Revision: 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int NREG = 16;
    localparam int AW   = 5;
    localparam int DW   = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    localparam logic [AW-1:0] ZERO_REG = '0;

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr.sv
// ============================================================================
// Module  : rr_arbiter2
// Brief   : Two-input round-robin arbiter; last-grant moves only on advance.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] request,
    input  logic       advance,
    output logic [1:0] grant
);

    req_id_e last_q;
    req_id_e last_d;

    always_comb begin
        grant = 2'b00;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_q == REQ_MEM) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase

        last_d = last_q;
        if (advance && (grant != 2'b00)) begin
            last_d = grant[1] ? REQ_MEM : REQ_ALU;
        end
    end

    // Starting at MEM hands the first contention to the ALU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= REQ_MEM;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module  : regfile_wb_arbiter
// Brief   : Round-robin write-back arbiter with a per-register busy scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREG = regfile_pkg::NREG,
    parameter int AW   = regfile_pkg::AW,
    parameter int DW   = regfile_pkg::DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd,
    output logic          iss_busy,
    input  logic [AW-1:0] RA,
    input  logic [AW-1:0] RB,
    output logic          busy_a,
    output logic          busy_b,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rd,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic          reg_write,
    output logic [AW-1:0] RW,
    output logic [DW-1:0] Bus_W,
    output logic          err_addr
);

    localparam int IW = $clog2(NREG);

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a != AW'(ZERO_REG)) && (32'(a) < NREG);
    endfunction

    function automatic logic busy_of(input logic [NREG-1:0] sb, input logic [AW-1:0] a);
        return in_range(a) ? sb[a[IW-1:0]] : 1'b0;
    endfunction

    logic [1:0]      w_grant;
    logic            w_xfer;
    logic [AW-1:0]   w_sel_rd;
    logic [DW-1:0]   w_sel_data;

    logic            reg_write_q, reg_write_d;
    logic            err_addr_q,  err_addr_d;
    logic [AW-1:0]   rw_q,        rw_d;
    logic [DW-1:0]   bus_w_q,     bus_w_d;
    logic [NREG-1:0] busy_q,      busy_d;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .request ({mem_valid, alu_valid}),
        .advance (w_xfer),
        .grant   (w_grant)
    );

    assign alu_ready  = w_grant[0];
    assign mem_ready  = w_grant[1];
    assign w_xfer     = |w_grant;
    assign w_sel_rd   = w_grant[1] ? mem_rd   : alu_rd;
    assign w_sel_data = w_grant[1] ? mem_data : alu_data;

    always_comb begin
        reg_write_d = w_xfer && in_range(w_sel_rd);
        err_addr_d  = w_xfer && (32'(w_sel_rd) >= NREG);
        rw_d        = reg_write_d ? w_sel_rd   : rw_q;
        bus_w_d     = reg_write_d ? w_sel_data : bus_w_q;

        // Clear first so a same-edge issue to the landing register stays busy.
        busy_d = busy_q;
        if (reg_write_q) begin
            busy_d[rw_q[IW-1:0]] = 1'b0;
        end
        if (iss_valid && in_range(iss_rd)) begin
            busy_d[iss_rd[IW-1:0]] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            err_addr_q  <= 1'b0;
            rw_q        <= '0;
            bus_w_q     <= '0;
            busy_q      <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            err_addr_q  <= err_addr_d;
            rw_q        <= rw_d;
            bus_w_q     <= bus_w_d;
            busy_q      <= busy_d;
        end
    end

    assign reg_write = reg_write_q;
    assign err_addr  = err_addr_q;
    assign RW        = rw_q;
    assign Bus_W     = bus_w_q;

    assign iss_busy  = busy_of(busy_q, iss_rd);
    assign busy_a    = busy_of(busy_q, RA);
    assign busy_b    = busy_of(busy_q, RB);

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module  : tb_regfile_wb_arbiter
// Brief   : Directed bench; expected write-backs queued, a monitor pops them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    logic          clk;
    logic          reset;
    logic          iss_valid;
    logic [AW-1:0] iss_rd;
    logic          iss_busy;
    logic [AW-1:0] RA, RB;
    logic          busy_a, busy_b;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          reg_write;
    logic [AW-1:0] RW;
    logic [DW-1:0] Bus_W;
    logic          err_addr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int            cyc;
        logic          is_err;
        logic [AW-1:0] rw;
        logic [DW-1:0] data;
    } exp_t;

    exp_t expq[$];

    regfile_wb_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_busy  (iss_busy),
        .RA        (RA),
        .RB        (RB),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .mem_valid (mem_valid),
        .mem_rd    (mem_rd),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .reg_write (reg_write),
        .RW        (RW),
        .Bus_W     (Bus_W),
        .err_addr  (err_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic push_wr(input logic [AW-1:0] rw, input logic [DW-1:0] data);
        exp_t e;
        e.cyc = cyc + 1; e.is_err = 1'b0; e.rw = rw; e.data = data;
        expq.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.cyc = cyc + 1; e.is_err = 1'b1; e.rw = '0; e.data = '0;
        expq.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: every reg_write or err_addr cycle must match the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reg_write || err_addr) begin
            checks++;
            if (expq.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected got reg_write=%0b err_addr=%0b RW=%0d Bus_W=%0h exp=none",
                         reg_write, err_addr, RW, Bus_W);
            end else begin
                e = expq.pop_front();
                if ((cyc != e.cyc) || (reg_write !== !e.is_err) || (err_addr !== e.is_err) ||
                    (!e.is_err && ((RW !== e.rw) || (Bus_W !== e.data)))) begin
                    errors++;
                    $display("FAIL wb_out got cyc=%0d we=%0b err=%0b RW=%0d Bus_W=%0h exp cyc=%0d we=%0b err=%0b RW=%0d Bus_W=%0h",
                             cyc, reg_write, err_addr, RW, Bus_W,
                             e.cyc, !e.is_err, e.is_err, e.rw, e.data);
                end
            end
        end
    end

    initial begin
        int rw_tab [8] = '{1, 9, 2, 10, 3, 11, 4, 12};
        int ai, mi;
        logic exp_alu;

        reset = 1'b1; iss_valid = 1'b0; iss_rd = '0; RA = '0; RB = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_reg_write", 32'(reg_write), 0);
        check("rst_RW",        32'(RW),        0);
        check("rst_Bus_W",     Bus_W,          0);
        check("rst_err_addr",  32'(err_addr),  0);
        reset = 1'b0;

        // Single ALU write-back after issue of r5
        iss_valid = 1'b1; iss_rd = 5;
        next();
        iss_valid = 1'b0; RA = 5;
        #1 check("issue_busy_r5", 32'(busy_a), 1);
        alu_valid = 1'b1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        #1 check("alu_ready_single", 32'(alu_ready), 1);
        check("mem_ready_idle", 32'(mem_ready), 0);
        push_wr(5, 32'hDEADBEEF);
        next();
        alu_valid = 1'b0;
        #1 check("busy_r5_while_writing", 32'(busy_a), 1);
        next();
        #1 check("busy_r5_cleared", 32'(busy_a), 0);

        // rd = 0 consumed silently
        alu_valid = 1'b1; alu_rd = 0; alu_data = 32'h1234;
        #1 check("alu_ready_rd0", 32'(alu_ready), 1);
        next();
        alu_valid = 1'b0;

        // rd out of range: single err_addr pulse, no write
        mem_valid = 1'b1; mem_rd = 20; mem_data = 32'h55;
        #1 check("mem_ready_rd20", 32'(mem_ready), 1);
        push_err();
        next();
        mem_valid = 1'b0;
        next();
        next();

        // Contention; last grant was MEM so ALU starts
        ai = 0; mi = 0;
        for (int k = 0; k < 8; k++) begin
            alu_valid = (ai < 4); alu_rd = AW'(1 + ai); alu_data = 32'hA000_0000 + 32'(ai);
            mem_valid = (mi < 4); mem_rd = AW'(9 + mi); mem_data = 32'hB000_0000 + 32'(mi);
            exp_alu = (rw_tab[k] < 9);
            #1 check($sformatf("cont_alu_ready_%0d", k), 32'(alu_ready), 32'(exp_alu));
            check($sformatf("cont_mem_ready_%0d", k), 32'(mem_ready), 32'(!exp_alu));
            if (exp_alu) begin
                push_wr(AW'(rw_tab[k]), 32'hA000_0000 + 32'(ai));
                ai++;
            end else begin
                push_wr(AW'(rw_tab[k]), 32'hB000_0000 + 32'(mi));
                mi++;
            end
            next();
        end
        alu_valid = 1'b0; mem_valid = 1'b0;

        // Same-edge set and clear of r7: set wins
        iss_valid = 1'b1; iss_rd = 7;
        next();
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 7; alu_data = 32'h77;
        push_wr(7, 32'h77);
        next();
        alu_valid = 1'b0;
        iss_valid = 1'b1; iss_rd = 7;
        #1 check("iss_busy_r7", 32'(iss_busy), 1);
        next();
        iss_valid = 1'b0; RA = 7;
        #1 check("same_edge_set_wins", 32'(busy_a), 1);

        // Hazard queries on r3
        iss_valid = 1'b1; iss_rd = 3;
        next();
        iss_valid = 1'b0; RA = 3; RB = 3;
        #1 check("haz_busy_a_r3", 32'(busy_a), 1);
        check("haz_busy_b_r3", 32'(busy_b), 1);
        check("haz_iss_busy_r3", 32'(iss_busy), 1);
        RA = 0;
        #1 check("haz_busy_a_r0", 32'(busy_a), 0);
        RA = 20;
        #1 check("haz_busy_a_r20", 32'(busy_a), 0);
        RA = 3;
        mem_valid = 1'b1; mem_rd = 3; mem_data = 32'h33;
        #1 check("mem_ready_r3", 32'(mem_ready), 1);
        push_wr(3, 32'h33);
        next();
        mem_valid = 1'b0;
        #1 check("haz_busy_a_pending", 32'(busy_a), 1);
        next();
        #1 check("haz_busy_a_landed", 32'(busy_a), 0);
        check("haz_busy_b_landed", 32'(busy_b), 0);

        // Reset mid-operation with an accepted write in flight
        for (int r = 0; r < 3; r++) begin
            iss_valid = 1'b1; iss_rd = (r == 2) ? AW'(4) : AW'(r + 1);
            next();
        end
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 6; alu_data = 32'h66;
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check("midrst_reg_write", 32'(reg_write), 0);
        check("midrst_RW",        32'(RW),        0);
        check("midrst_Bus_W",     Bus_W,          0);
        check("midrst_err_addr",  32'(err_addr),  0);
        alu_valid = 1'b0; RA = 1; RB = 2; iss_rd = 4;
        #1 check("midrst_busy_a_r1", 32'(busy_a), 0);
        check("midrst_busy_b_r2", 32'(busy_b), 0);
        check("midrst_iss_busy_r4", 32'(iss_busy), 0);
        RA = 7;
        #1 check("midrst_busy_r7", 32'(busy_a), 0);
        @(negedge clk);
        reset = 1'b0;

        // First contention after reset goes to ALU
        alu_valid = 1'b1; alu_rd = 8; alu_data = 32'h88;
        mem_valid = 1'b1; mem_rd = 9; mem_data = 32'h99;
        #1 check("postrst_alu_wins", 32'(alu_ready), 1);
        check("postrst_mem_waits", 32'(mem_ready), 0);
        push_wr(8, 32'h88);
        next();
        alu_valid = 1'b0;
        #1 check("postrst_mem_next", 32'(mem_ready), 1);
        push_wr(9, 32'h99);
        next();
        mem_valid = 1'b0;
        next();
        next();

        check("queue_drained", 32'(expq.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
